dual_mode_buf: RTL and testbench

DUAL_MODE_BUF -- requirements
Module: dual_mode_buf

---
 rtl/buf_pkg.sv | 17 +
 rtl/buf_ram.sv | 36 +++
 rtl/dual_mode_buf.sv | 116 +++++++++++
 tb/tb_dual_mode_buf.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/buf_pkg.sv
// Shared types and flag-threshold helpers for the dual-mode (LIFO/FIFO) buffer.
package buf_pkg;

  typedef enum logic {
    MODE_LIFO = 1'b0,
    MODE_FIFO = 1'b1
  } mode_t;

  function automatic logic almost_empty_flag(input int used, input int threshold);
    return used <= threshold;
  endfunction

  function automatic logic almost_full_flag(input int used, input int depth, input int margin);
    return used >= (depth - margin);
  endfunction

endpackage

// File: rtl/buf_ram.sv
// Simple dual-port storage, one write port and one read port with a registered,
// enable-gated read so the output holds its last word between reads.
module buf_ram #(
  parameter int DWIDTH = 16,
  parameter int AWIDTH = 8
) (
  input  logic              clk,
  input  logic              srst,
  input  logic              we,
  input  logic [AWIDTH-1:0] waddr,
  input  logic [DWIDTH-1:0] wdata,
  input  logic              re,
  input  logic [AWIDTH-1:0] raddr,
  output logic [DWIDTH-1:0] rdata
);

  localparam int DEPTH = 2 ** AWIDTH;

  logic [DWIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Read-before-write on a shared address: a simultaneous pop+push returns the old word.
  always_ff @(posedge clk) begin
    if (srst) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/dual_mode_buf.sv
// Buffer that behaves as a stack (LIFO) or queue (FIFO); control, counters and
// flags live here, storage sits in buf_ram.
module dual_mode_buf
  import buf_pkg::*;
#(
  parameter int DWIDTH       = 16,
  parameter int AWIDTH       = 8,
  parameter int ALMOST_FULL  = 2,
  parameter int ALMOST_EMPTY = 2
) (
  input  logic              clk_i,
  input  logic              srst_i,
  input  logic              mode_i,
  input  logic              wrreq_i,
  input  logic [DWIDTH-1:0] data_i,
  input  logic              rdreq_i,
  output logic [DWIDTH-1:0] q_o,
  output logic              mode_o,
  output logic [AWIDTH:0]   usedw_o,
  output logic              empty_o,
  output logic              almost_empty_o,
  output logic              full_o,
  output logic              almost_full_o,
  output logic              ovf_o,
  output logic              udf_o
);

  localparam int              DEPTH   = 2 ** AWIDTH;
  localparam logic [AWIDTH:0] DEPTH_W = (AWIDTH + 1)'(DEPTH);

  logic [AWIDTH:0]   count_reg, count_next, top_m1;
  logic [AWIDTH-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [AWIDTH-1:0] waddr, raddr;
  mode_t             mode_reg;
  logic              empty_reg, almost_empty_reg, full_reg, almost_full_reg;
  logic              ovf_reg, udf_reg;
  logic              wr_ok, rd_ok, mode_load;

  assign top_m1 = count_reg - 1'b1;

  always_comb begin
    rd_ok      = rdreq_i && (count_reg != '0);
    // A write at full still fits when a read frees a slot in the same cycle.
    wr_ok      = wrreq_i && ((count_reg != DEPTH_W) || rd_ok);
    mode_load  = (count_reg == '0) && !wrreq_i;
    count_next = count_reg;
    if (wr_ok && !rd_ok) begin
      count_next = count_reg + 1'b1;
    end else if (rd_ok && !wr_ok) begin
      count_next = count_reg - 1'b1;
    end
    if (mode_reg == MODE_FIFO) begin
      waddr = wr_ptr_reg;
      raddr = rd_ptr_reg;
    end else begin
      // Stack: top lives at count-1; a push+pop replaces the top in place.
      raddr = top_m1[AWIDTH-1:0];
      waddr = rd_ok ? top_m1[AWIDTH-1:0] : count_reg[AWIDTH-1:0];
    end
  end

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      count_reg        <= '0;
      wr_ptr_reg       <= '0;
      rd_ptr_reg       <= '0;
      mode_reg         <= mode_t'(mode_i);
      empty_reg        <= 1'b1;
      almost_empty_reg <= 1'b1;
      full_reg         <= 1'b0;
      almost_full_reg  <= 1'b0;
      ovf_reg          <= 1'b0;
      udf_reg          <= 1'b0;
    end else begin
      count_reg        <= count_next;
      empty_reg        <= (count_next == '0);
      full_reg         <= (count_next == DEPTH_W);
      almost_empty_reg <= almost_empty_flag(int'(count_next), ALMOST_EMPTY);
      almost_full_reg  <= almost_full_flag(int'(count_next), DEPTH, ALMOST_FULL);
      ovf_reg          <= wrreq_i && !wr_ok;
      udf_reg          <= rdreq_i && !rd_ok;
      if (mode_load && (mode_t'(mode_i) != mode_reg)) begin
        mode_reg   <= mode_t'(mode_i);
        wr_ptr_reg <= '0;
        rd_ptr_reg <= '0;
      end else begin
        if (wr_ok) wr_ptr_reg <= wr_ptr_reg + 1'b1;
        if (rd_ok) rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
    end
  end

  buf_ram #(
    .DWIDTH(DWIDTH),
    .AWIDTH(AWIDTH)
  ) u_ram (
    .clk  (clk_i),
    .srst (srst_i),
    .we   (wr_ok && !srst_i),
    .waddr(waddr),
    .wdata(data_i),
    .re   (rd_ok && !srst_i),
    .raddr(raddr),
    .rdata(q_o)
  );

  assign mode_o         = mode_reg;
  assign usedw_o        = count_reg;
  assign empty_o        = empty_reg;
  assign almost_empty_o = almost_empty_reg;
  assign full_o         = full_reg;
  assign almost_full_o  = almost_full_reg;
  assign ovf_o          = ovf_reg;
  assign udf_o          = udf_reg;

endmodule

// File: tb/tb_dual_mode_buf.sv
// Directed bench for dual_mode_buf: LIFO/FIFO ordering, wrap, overflow, underflow,
// simultaneous access, mode gating and reset.
module tb_dual_mode_buf;

  logic        clk_i = 1'b0;
  logic        srst_i = 1'b0;
  logic        mode_i = 1'b0;
  logic        wrreq_i = 1'b0;
  logic [15:0] data_i = '0;
  logic        rdreq_i = 1'b0;
  logic [15:0] q_o;
  logic        mode_o;
  logic [8:0]  usedw_o;
  logic        empty_o, almost_empty_o, full_o, almost_full_o, ovf_o, udf_o;

  int errors = 0;
  int checks = 0;

  dual_mode_buf dut (
    .clk_i(clk_i), .srst_i(srst_i), .mode_i(mode_i), .wrreq_i(wrreq_i),
    .data_i(data_i), .rdreq_i(rdreq_i), .q_o(q_o), .mode_o(mode_o),
    .usedw_o(usedw_o), .empty_o(empty_o), .almost_empty_o(almost_empty_o),
    .full_o(full_o), .almost_full_o(almost_full_o), .ovf_o(ovf_o), .udf_o(udf_o)
  );

  always #5 clk_i = ~clk_i;

  // One clock of stimulus; outputs are stable 1 time unit after the edge.
  task automatic step(input logic w, input logic [15:0] d, input logic r);
    wrreq_i = w;
    data_i  = d;
    rdreq_i = r;
    @(posedge clk_i);
    #1;
    wrreq_i = 1'b0;
    rdreq_i = 1'b0;
    $display("t=%0t srst=%0b mode_i=%0b wr=%0b d=%h rd=%0b -> q=%h usedw=%0d e=%0b ae=%0b f=%0b af=%0b ovf=%0b udf=%0b mode=%0b",
             $time, srst_i, mode_i, w, d, r, q_o, usedw_o, empty_o, almost_empty_o,
             full_o, almost_full_o, ovf_o, udf_o, mode_o);
  endtask

  task automatic do_reset(input logic m);
    srst_i = 1'b1;
    mode_i = m;
    step(1'b0, 16'h0, 1'b0);
    srst_i = 1'b0;
  endtask

  task automatic test_reset();
    do_reset(1'b0);
    checks++; if (usedw_o !== 9'd0)   begin errors++; $display("FAIL reset_usedw got=%0d exp=0", usedw_o); end
    checks++; if (empty_o !== 1'b1)   begin errors++; $display("FAIL reset_empty got=%0b exp=1", empty_o); end
    checks++; if (almost_empty_o !== 1'b1) begin errors++; $display("FAIL reset_ae got=%0b exp=1", almost_empty_o); end
    checks++; if (full_o !== 1'b0)    begin errors++; $display("FAIL reset_full got=%0b exp=0", full_o); end
    checks++; if (almost_full_o !== 1'b0) begin errors++; $display("FAIL reset_af got=%0b exp=0", almost_full_o); end
    checks++; if ({ovf_o, udf_o} !== 2'b00) begin errors++; $display("FAIL reset_pulses got=%b exp=00", {ovf_o, udf_o}); end
    checks++; if (q_o !== 16'h0)      begin errors++; $display("FAIL reset_q got=%h exp=0000", q_o); end
    checks++; if (mode_o !== 1'b0)    begin errors++; $display("FAIL reset_mode got=%0b exp=0", mode_o); end
  endtask

  task automatic test_lifo();
    do_reset(1'b0);
    for (int i = 1; i <= 10; i++) begin
      step(1'b1, 16'(i), 1'b0);
      checks++; if (usedw_o !== 9'(i)) begin errors++; $display("FAIL lifo_usedw_wr got=%0d exp=%0d", usedw_o, i); end
      checks++; if (almost_empty_o !== (i <= 2)) begin errors++; $display("FAIL lifo_ae got=%0b exp=%0b", almost_empty_o, (i <= 2)); end
    end
    for (int i = 1; i <= 10; i++) begin
      step(1'b0, 16'h0, 1'b1);
      checks++; if (q_o !== 16'(11 - i)) begin errors++; $display("FAIL lifo_q got=%h exp=%h", q_o, 16'(11 - i)); end
      checks++; if (usedw_o !== 9'(10 - i)) begin errors++; $display("FAIL lifo_usedw_rd got=%0d exp=%0d", usedw_o, 10 - i); end
    end
    checks++; if (empty_o !== 1'b1) begin errors++; $display("FAIL lifo_empty_end got=%0b exp=1", empty_o); end
  endtask

  task automatic test_fifo();
    logic [15:0] model[$];
    logic [15:0] exp_q;
    int n;
    do_reset(1'b1);
    checks++; if (mode_o !== 1'b1) begin errors++; $display("FAIL fifo_mode_from_reset got=%0b exp=1", mode_o); end
    for (int i = 1; i <= 10; i++) step(1'b1, 16'(i), 1'b0);
    exp_q = 16'h0;
    n = 0;
    while (n < 10) begin
      if ($urandom_range(0, 9) < 3) begin
        step(1'b0, 16'h0, 1'b0);
        checks++; if (q_o !== exp_q) begin errors++; $display("FAIL fifo_gap_hold got=%h exp=%h", q_o, exp_q); end
      end else begin
        n++;
        exp_q = 16'(n);
        step(1'b0, 16'h0, 1'b1);
        checks++; if (q_o !== exp_q) begin errors++; $display("FAIL fifo_q got=%h exp=%h", q_o, exp_q); end
      end
    end
    // 300 words through a 256-deep queue whose pointers start at 10: both wrap.
    for (int i = 0; i < 50; i++) begin
      step(1'b1, 16'(1000 + i), 1'b0);
      model.push_back(16'(1000 + i));
    end
    for (int i = 50; i < 300; i++) begin
      exp_q = model.pop_front();
      step(1'b1, 16'(1000 + i), 1'b1);
      model.push_back(16'(1000 + i));
      checks++; if (q_o !== exp_q) begin errors++; $display("FAIL fifo_wrap_q got=%h exp=%h", q_o, exp_q); end
    end
    checks++; if (usedw_o !== 9'd50) begin errors++; $display("FAIL fifo_wrap_usedw got=%0d exp=50", usedw_o); end
    for (int i = 0; i < 50; i++) begin
      exp_q = model.pop_front();
      step(1'b0, 16'h0, 1'b1);
      checks++; if (q_o !== exp_q) begin errors++; $display("FAIL fifo_drain_q got=%h exp=%h", q_o, exp_q); end
    end
    checks++; if (empty_o !== 1'b1) begin errors++; $display("FAIL fifo_empty_end got=%0b exp=1", empty_o); end
  endtask

  task automatic test_overflow(input logic m);
    logic [15:0] model[$];
    logic [15:0] exp_q;
    do_reset(m);
    for (int i = 1; i <= 256; i++) begin
      step(1'b1, 16'(i * 7 + 3), 1'b0);
      model.push_back(16'(i * 7 + 3));
      if (i >= 252) begin
        checks++; if (almost_full_o !== (i >= 254)) begin errors++; $display("FAIL ovf_af m=%0b usedw=%0d got=%0b exp=%0b", m, i, almost_full_o, (i >= 254)); end
        checks++; if (full_o !== (i == 256)) begin errors++; $display("FAIL ovf_full m=%0b usedw=%0d got=%0b exp=%0b", m, i, full_o, (i == 256)); end
      end
    end
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 16'hABBA, 1'b0);
      checks++; if (ovf_o !== 1'b1) begin errors++; $display("FAIL ovf_pulse m=%0b got=%0b exp=1", m, ovf_o); end
      checks++; if (usedw_o !== 9'd256) begin errors++; $display("FAIL ovf_usedw m=%0b got=%0d exp=256", m, usedw_o); end
    end
    step(1'b0, 16'h0, 1'b0);
    checks++; if (ovf_o !== 1'b0) begin errors++; $display("FAIL ovf_pulse_clear m=%0b got=%0b exp=0", m, ovf_o); end
    // Push+pop at full is accepted without an overflow pulse.
    exp_q = m ? model.pop_front() : model.pop_back();
    step(1'b1, 16'h5A5A, 1'b1);
    model.push_back(16'h5A5A);
    checks++; if (q_o !== exp_q) begin errors++; $display("FAIL full_rw_q m=%0b got=%h exp=%h", m, q_o, exp_q); end
    checks++; if (ovf_o !== 1'b0) begin errors++; $display("FAIL full_rw_ovf m=%0b got=%0b exp=0", m, ovf_o); end
    checks++; if (usedw_o !== 9'd256) begin errors++; $display("FAIL full_rw_usedw m=%0b got=%0d exp=256", m, usedw_o); end
    for (int i = 255; i >= 0; i--) begin
      exp_q = m ? model.pop_front() : model.pop_back();
      step(1'b0, 16'h0, 1'b1);
      checks++; if (q_o !== exp_q) begin errors++; $display("FAIL ovf_drain_q m=%0b got=%h exp=%h", m, q_o, exp_q); end
      if (i <= 3) begin
        checks++; if (almost_empty_o !== (i <= 2)) begin errors++; $display("FAIL drain_ae m=%0b usedw=%0d got=%0b exp=%0b", m, i, almost_empty_o, (i <= 2)); end
      end
    end
    checks++; if (empty_o !== 1'b1) begin errors++; $display("FAIL ovf_empty_end m=%0b got=%0b exp=1", m, empty_o); end
  endtask

  task automatic test_underflow();
    logic [15:0] vals [3];
    vals[0] = 16'hAAAA; vals[1] = 16'hBBBB; vals[2] = 16'hCCCC;
    do_reset(1'b0);
    for (int i = 0; i < 3; i++) step(1'b1, vals[i], 1'b0);
    for (int i = 2; i >= 0; i--) begin
      step(1'b0, 16'h0, 1'b1);
      checks++; if (q_o !== vals[i]) begin errors++; $display("FAIL udf_read got=%h exp=%h", q_o, vals[i]); end
    end
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 16'h0, 1'b1);
      checks++; if (udf_o !== 1'b1) begin errors++; $display("FAIL udf_pulse got=%0b exp=1", udf_o); end
      checks++; if (q_o !== 16'hAAAA) begin errors++; $display("FAIL udf_q_hold got=%h exp=aaaa", q_o); end
      checks++; if (usedw_o !== 9'd0) begin errors++; $display("FAIL udf_usedw got=%0d exp=0", usedw_o); end
    end
    // Push+pop while empty: the write lands, the read is dropped.
    step(1'b1, 16'h1234, 1'b1);
    checks++; if (udf_o !== 1'b1) begin errors++; $display("FAIL empty_rw_udf got=%0b exp=1", udf_o); end
    checks++; if (usedw_o !== 9'd1) begin errors++; $display("FAIL empty_rw_usedw got=%0d exp=1", usedw_o); end
    checks++; if (q_o !== 16'hAAAA) begin errors++; $display("FAIL empty_rw_q got=%h exp=aaaa", q_o); end
    step(1'b0, 16'h0, 1'b1);
    checks++; if (q_o !== 16'h1234) begin errors++; $display("FAIL empty_rw_read got=%h exp=1234", q_o); end
    checks++; if (udf_o !== 1'b0) begin errors++; $display("FAIL empty_rw_udf_clear got=%0b exp=0", udf_o); end
  endtask

  task automatic test_back_to_back();
    logic [15:0] r [11];
    logic [15:0] exp_q;
    do_reset(1'b0);
    for (int i = 1; i <= 10; i++) step(1'b1, 16'(i), 1'b0);
    for (int k = 1; k <= 10; k++) begin
      r[k] = 16'($urandom_range(16'h100, 16'hFFFF));
      exp_q = (k == 1) ? 16'd10 : r[k - 1];
      step(1'b1, r[k], 1'b1);
      checks++; if (q_o !== exp_q) begin errors++; $display("FAIL b2b_q k=%0d got=%h exp=%h", k, q_o, exp_q); end
      checks++; if (usedw_o !== 9'd10) begin errors++; $display("FAIL b2b_usedw k=%0d got=%0d exp=10", k, usedw_o); end
    end
    for (int i = 10; i >= 1; i--) begin
      exp_q = (i == 10) ? r[10] : 16'(i);
      step(1'b0, 16'h0, 1'b1);
      checks++; if (q_o !== exp_q) begin errors++; $display("FAIL b2b_drain got=%h exp=%h", q_o, exp_q); end
    end
  endtask

  task automatic test_mode_reset();
    do_reset(1'b0);
    for (int i = 1; i <= 3; i++) step(1'b1, 16'(i), 1'b0);
    mode_i = 1'b1;
    step(1'b0, 16'h0, 1'b0);
    checks++; if (mode_o !== 1'b0) begin errors++; $display("FAIL mode_ignored_nonempty got=%0b exp=0", mode_o); end
    step(1'b1, 16'd4, 1'b0);
    step(1'b1, 16'd5, 1'b0);
    checks++; if (mode_o !== 1'b0) begin errors++; $display("FAIL mode_ignored_burst got=%0b exp=0", mode_o); end
    checks++; if (usedw_o !== 9'd5) begin errors++; $display("FAIL mode_pre_reset_usedw got=%0d exp=5", usedw_o); end
    srst_i = 1'b1;
    step(1'b1, 16'h7777, 1'b1);
    srst_i = 1'b0;
    checks++; if (usedw_o !== 9'd0) begin errors++; $display("FAIL midburst_usedw got=%0d exp=0", usedw_o); end
    checks++; if (empty_o !== 1'b1) begin errors++; $display("FAIL midburst_empty got=%0b exp=1", empty_o); end
    checks++; if (mode_o !== 1'b1) begin errors++; $display("FAIL midburst_mode got=%0b exp=1", mode_o); end
    checks++; if (q_o !== 16'h0) begin errors++; $display("FAIL midburst_q got=%h exp=0000", q_o); end
    step(1'b0, 16'h0, 1'b1);
    checks++; if (udf_o !== 1'b1 || q_o !== 16'h0) begin errors++; $display("FAIL stale_read udf=%0b q=%h exp udf=1 q=0000", udf_o, q_o); end
    mode_i = 1'b0;
    step(1'b0, 16'h0, 1'b0);
    checks++; if (mode_o !== 1'b0) begin errors++; $display("FAIL mode_switch_empty got=%0b exp=0", mode_o); end
    mode_i = 1'b1;
    step(1'b1, 16'h4444, 1'b0);
    checks++; if (mode_o !== 1'b0) begin errors++; $display("FAIL mode_ignored_with_write got=%0b exp=0", mode_o); end
  endtask

  initial begin
    test_reset();
    test_lifo();
    test_fifo();
    test_overflow(1'b0);
    test_overflow(1'b1);
    test_underflow();
    test_back_to_back();
    test_mode_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
